// File: rtl/sclk_ctrl_pkg.sv
// Shared state encoding and default parameter values for the burst clock generator.
package sclk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sclk_state_e;

  localparam int unsigned SCLK_DEF_BITS_NUMBER  = 8;
  localparam int unsigned SCLK_DEF_CNT_BITS     = 8;
  localparam int unsigned SCLK_DEF_INIT_DIVIDER = 125;

endpackage

// File: rtl/sclk_phase_counter.sv
// Loadable half-period down-counter; tc_o is high while the count sits at zero.
// A load of H-1 therefore yields a phase of exactly H cycles.
module sclk_phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sclk_burst_controller.sv
// Generates bursts of N periods of a divided clock (half-period H) on request.
// Optional continuous mode is enabled by defining SCLK_FREE_RUN_EN (adds the FreeRun input).
module sclk_burst_controller
  import sclk_ctrl_pkg::*;
#(
  parameter int unsigned BITS_NUMBER  = SCLK_DEF_BITS_NUMBER,
  parameter int unsigned CNT_BITS     = SCLK_DEF_CNT_BITS,
  parameter int unsigned INIT_DIVIDER = SCLK_DEF_INIT_DIVIDER
) (
  input  logic                   InputCLK,
  input  logic                   Rst,
  input  logic                   DivValid,
  output logic                   DivReady,
  input  logic [BITS_NUMBER-1:0] DivValue,
  input  logic                   BurstValid,
  output logic                   BurstReady,
  input  logic [CNT_BITS-1:0]    BurstLen,
`ifdef SCLK_FREE_RUN_EN
  input  logic                   FreeRun,
`endif
  output logic                   OutputCLK,
  output logic                   RiseStrobe,
  output logic                   FallStrobe,
  output logic                   Busy,
  output logic                   Done
);

  sclk_state_e          state_q, state_d;
  logic [BITS_NUMBER-1:0] half_q, half_d;
  logic [CNT_BITS-1:0]  remain_q, remain_d;
  logic clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic busy_q, busy_d, done_q, done_d;
  logic dready_q, dready_d, bready_q, bready_d;
  logic div_fire, burst_fire;
  logic ph_load, ph_en, ph_tc;
`ifdef SCLK_FREE_RUN_EN
  logic free_q, free_d;
`endif

  // A divider update wins over a simultaneous burst request so the burst sees the new H.
  assign div_fire   = DivValid & dready_q;
  assign burst_fire = BurstValid & bready_q & ~div_fire;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    remain_d = remain_q;
    clk_d    = clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ph_load  = 1'b0;
    ph_en    = 1'b0;
`ifdef SCLK_FREE_RUN_EN
    free_d   = free_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (div_fire) begin
          half_d = (DivValue == '0) ? BITS_NUMBER'(1) : DivValue;
        end else if (burst_fire) begin
          if (BurstLen == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            clk_d    = 1'b1;
            rise_d   = 1'b1;
            busy_d   = 1'b1;
            remain_d = BurstLen;
            ph_load  = 1'b1;
          end
`ifdef SCLK_FREE_RUN_EN
        end else if (FreeRun && dready_q) begin
          state_d = ST_HIGH;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          busy_d  = 1'b1;
          free_d  = 1'b1;
          ph_load = 1'b1;
`endif
        end
      end
      ST_HIGH: begin
        ph_en = 1'b1;
        if (ph_tc) begin
          state_d = ST_LOW;
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          ph_load = 1'b1;
        end
      end
      ST_LOW: begin
        ph_en = 1'b1;
        if (ph_tc) begin
`ifdef SCLK_FREE_RUN_EN
          if (free_q) begin
            if (FreeRun) begin
              state_d = ST_HIGH;
              clk_d   = 1'b1;
              rise_d  = 1'b1;
              ph_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              free_d  = 1'b0;
            end
          end else
`endif
          begin
            remain_d = remain_q - 1'b1;
            if (remain_q == CNT_BITS'(1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HIGH;
              clk_d   = 1'b1;
              rise_d  = 1'b1;
              ph_load = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is withheld during the Done cycle and for one cycle after a divider update.
    dready_d = (state_d == ST_IDLE) && !done_d;
    bready_d = dready_d && !div_fire;
  end

  always_ff @(posedge InputCLK or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      half_q   <= BITS_NUMBER'(INIT_DIVIDER);
      remain_q <= '0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dready_q <= 1'b0;
      bready_q <= 1'b0;
`ifdef SCLK_FREE_RUN_EN
      free_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      remain_q <= remain_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dready_q <= dready_d;
      bready_q <= bready_d;
`ifdef SCLK_FREE_RUN_EN
      free_q   <= free_d;
`endif
    end
  end

  sclk_phase_counter #(
    .W(BITS_NUMBER)
  ) u_phase (
    .clk_i      (InputCLK),
    .rst_n_i    (Rst),
    .load_i     (ph_load),
    .load_val_i (half_q - 1'b1),
    .en_i       (ph_en),
    .tc_o       (ph_tc)
  );

  assign OutputCLK  = clk_q;
  assign RiseStrobe = rise_q;
  assign FallStrobe = fall_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign DivReady   = dready_q;
  assign BurstReady = bready_q;

endmodule

// File: tb/tb_sclk_burst_controller.sv
// Directed bench for sclk_burst_controller; free-run steps only when SCLK_FREE_RUN_EN is defined.
module tb_sclk_burst_controller;

  logic       InputCLK;
  logic       Rst;
  logic       DivValid, DivReady, BurstValid, BurstReady;
  logic [7:0] DivValue, BurstLen;
  logic       OutputCLK, RiseStrobe, FallStrobe, Busy, Done;
`ifdef SCLK_FREE_RUN_EN
  logic       FreeRun;
`endif

  int total = 0;
  int bad   = 0;

  sclk_burst_controller dut (
    .InputCLK   (InputCLK),
    .Rst        (Rst),
    .DivValid   (DivValid),
    .DivReady   (DivReady),
    .DivValue   (DivValue),
    .BurstValid (BurstValid),
    .BurstReady (BurstReady),
    .BurstLen   (BurstLen),
`ifdef SCLK_FREE_RUN_EN
    .FreeRun    (FreeRun),
`endif
    .OutputCLK  (OutputCLK),
    .RiseStrobe (RiseStrobe),
    .FallStrobe (FallStrobe),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial begin
    InputCLK = 1'b0;
    forever #5 InputCLK = ~InputCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with both readies high; returns at the negedge of the Done cycle.
  task automatic run_burst(input logic [7:0] n, output int len, output int rises,
                           output int falls, output int highs, output logic [15:0] pat,
                           output logic first_ok, output logic got_done);
    BurstValid = 1'b1;
    BurstLen   = n;
    @(posedge InputCLK);
    #1 BurstValid = 1'b0;
    len = 0; rises = 0; falls = 0; highs = 0; pat = '0; first_ok = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge InputCLK);
      if (i == 0) first_ok = OutputCLK && RiseStrobe && Busy;
      if (Done) begin
        got_done = 1'b1;
        break;
      end
      len++;
      rises += int'(RiseStrobe);
      falls += int'(FallStrobe);
      highs += int'(OutputCLK);
      pat = {pat[14:0], OutputCLK};
    end
  endtask

  task automatic set_div(input logic [7:0] v);
    DivValid = 1'b1;
    DivValue = v;
    @(posedge InputCLK);
    #1 DivValid = 1'b0;
    @(negedge InputCLK);
    @(negedge InputCLK);
  endtask

  initial begin
    int len, rises, falls, highs;
    logic [15:0] pat;
    logic first_ok, got_done;

    Rst = 1'b1; DivValid = 1'b0; BurstValid = 1'b0; DivValue = '0; BurstLen = '0;
`ifdef SCLK_FREE_RUN_EN
    FreeRun = 1'b0;
`endif
    #2 Rst = 1'b0;
    repeat (3) @(negedge InputCLK);
    check("rst_outclk", OutputCLK, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_divrdy", DivReady, 1'b0);
    check("rst_burstrdy", BurstReady, 1'b0);
    Rst = 1'b1;
    @(negedge InputCLK);
    check("rel_divrdy", DivReady, 1'b1);
    check("rel_burstrdy", BurstReady, 1'b1);

    // N=3 at the reset divider of 125
    run_burst(8'd3, len, rises, falls, highs, pat, first_ok, got_done);
    check("b3_done_seen", got_done, 1'b1);
    check("b3_first", first_ok, 1'b1);
    check("b3_len", len, 750);
    check("b3_rises", rises, 3);
    check("b3_falls", falls, 3);
    check("b3_highs", highs, 375);
    check("b3_donecyc_busy", Busy, 1'b0);
    check("b3_donecyc_clk", OutputCLK, 1'b0);
    check("b3_donecyc_divrdy", DivReady, 1'b0);
    check("b3_donecyc_burstrdy", BurstReady, 1'b0);
    @(negedge InputCLK);
    check("b3_after_done", Done, 1'b0);
    check("b3_after_rdy", BurstReady, 1'b1);

    // H=5, N=4
    set_div(8'd5);
    run_burst(8'd4, len, rises, falls, highs, pat, first_ok, got_done);
    check("h5_done_seen", got_done, 1'b1);
    check("h5_len", len, 40);
    check("h5_pattern", pat, 16'h83E0);
    check("h5_rises", rises, 4);
    @(negedge InputCLK);

    // Divider and burst presented together: divider first, burst later with H=2
    DivValid = 1'b1; DivValue = 8'd2; BurstValid = 1'b1; BurstLen = 8'd2;
    @(posedge InputCLK);
    #1 DivValid = 1'b0;
    @(negedge InputCLK);
    check("both_burstrdy", BurstReady, 1'b0);
    check("both_busy", Busy, 1'b0);
    check("both_divrdy", DivReady, 1'b1);
    @(negedge InputCLK);
    check("both_busy2", Busy, 1'b0);
    check("both_burstrdy2", BurstReady, 1'b1);
    run_burst(8'd2, len, rises, falls, highs, pat, first_ok, got_done);
    check("h2_done_seen", got_done, 1'b1);
    check("h2_len", len, 8);
    check("h2_pattern", pat, 16'h00CC);
    @(negedge InputCLK);

    // DivValue 0 becomes H=1
    set_div(8'd0);
    run_burst(8'd1, len, rises, falls, highs, pat, first_ok, got_done);
    check("h1_done_seen", got_done, 1'b1);
    check("h1_len", len, 2);
    check("h1_pattern", pat, 16'h0002);
    check("h1_falls", falls, 1);
    @(negedge InputCLK);

    // Zero-length burst: Done next cycle, no pulse
    BurstValid = 1'b1; BurstLen = 8'd0;
    @(posedge InputCLK);
    #1 BurstValid = 1'b0;
    @(negedge InputCLK);
    check("n0_done", Done, 1'b1);
    check("n0_busy", Busy, 1'b0);
    check("n0_clk", OutputCLK, 1'b0);
    check("n0_rise", RiseStrobe, 1'b0);
    @(negedge InputCLK);
    check("n0_done_clear", Done, 1'b0);
    check("n0_rdy", BurstReady, 1'b1);

    // Maximum burst length and maximum divider
    run_burst(8'd255, len, rises, falls, highs, pat, first_ok, got_done);
    check("nmax_done_seen", got_done, 1'b1);
    check("nmax_len", len, 510);
    check("nmax_rises", rises, 255);
    @(negedge InputCLK);
    set_div(8'd255);
    run_burst(8'd1, len, rises, falls, highs, pat, first_ok, got_done);
    check("hmax_done_seen", got_done, 1'b1);
    check("hmax_len", len, 510);
    check("hmax_highs", highs, 255);
    @(negedge InputCLK);

    // Reset during the second HIGH phase of an N=5 burst with H=4
    set_div(8'd4);
    BurstValid = 1'b1; BurstLen = 8'd5;
    @(posedge InputCLK);
    #1 BurstValid = 1'b0;
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge InputCLK);
      if (RiseStrobe) rises++;
      if (rises == 2) break;
    end
    check("abort_second_rise", rises, 2);
    check("abort_clk_before", OutputCLK, 1'b1);
    #2 Rst = 1'b0;
    #1;
    check("abort_clk", OutputCLK, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_divrdy", DivReady, 1'b0);
    @(negedge InputCLK);
    check("abort_done", Done, 1'b0);
    Rst = 1'b1;
    @(negedge InputCLK);
    check("abort_rel_divrdy", DivReady, 1'b1);
    check("abort_rel_burstrdy", BurstReady, 1'b1);
    check("abort_rel_done", Done, 1'b0);
    run_burst(8'd1, len, rises, falls, highs, pat, first_ok, got_done);
    check("abort_h_restored", len, 250);
    @(negedge InputCLK);

`ifdef SCLK_FREE_RUN_EN
    begin
      int busy_cnt, done_cnt, rdy_cnt;
      logic stopped;
      set_div(8'd3);
      FreeRun = 1'b1;
      busy_cnt = 0; done_cnt = 0; rdy_cnt = 0; rises = 0; falls = 0; stopped = 1'b0;
      for (int k = 1; k < 300; k++) begin
        @(negedge InputCLK);
        if (k == 20) FreeRun = 1'b0;
        if (!Busy && k > 1) begin
          stopped = 1'b1;
          break;
        end
        busy_cnt += int'(Busy);
        done_cnt += int'(Done);
        rdy_cnt  += int'(BurstReady | DivReady);
        rises    += int'(RiseStrobe);
        falls    += int'(FallStrobe);
      end
      check("fr_stopped", stopped, 1'b1);
      check("fr_busy_cycles", busy_cnt, 24);
      check("fr_rises", rises, 4);
      check("fr_falls", falls, 4);
      check("fr_no_done", done_cnt, 0);
      check("fr_no_ready", rdy_cnt, 0);
      check("fr_end_clk", OutputCLK, 1'b0);
      check("fr_end_done", Done, 1'b0);
      check("fr_end_rdy", DivReady, 1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sclk_burst_controller.md
SCLK_BURST_CONTROLLER -- requirements
Module: sclk_burst_controller

Interface
REQ-001 SHALL have parameter BITS_NUMBER, default 8, width of half-period divider value.
REQ-002 SHALL have parameter CNT_BITS, default 8, width of burst length.
REQ-003 SHALL have parameter INIT_DIVIDER, default 125, half-period in InputCLK cycles after reset.
REQ-004 SHALL have port InputCLK  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port Rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports DivValid in 1, DivReady out 1, DivValue in BITS_NUMBER: divider-change handshake (half-period in cycles).
REQ-007 SHALL have ports BurstValid in 1, BurstReady out 1, BurstLen in CNT_BITS: burst-request handshake (number of output periods).
REQ-008 SHALL have port OutputCLK  out  1  generated clock, idle low.
REQ-009 SHALL have ports RiseStrobe out 1, FallStrobe out 1: one-cycle pulses in the first cycle OutputCLK is high / low.
REQ-010 SHALL have ports Busy out 1 (burst in progress) and Done out 1 (one-cycle pulse at burst end).

Function
REQ-011 SHALL implement FSM states IDLE, HIGH, LOW; all outputs registered.
REQ-012 Handshake transfer SHALL occur on a rising edge where Valid and Ready are both 1; Ready SHALL NOT depend combinationally on Valid.
REQ-013 DivReady and BurstReady SHALL be 1 only in IDLE; both 0 in HIGH/LOW and in the cycle Done is asserted.
REQ-014 An accepted DivValue SHALL be stored as the active half-period H; value 0 SHALL be stored as 1.
REQ-015 DivValid and BurstValid both asserted in IDLE: divider accepted, BurstReady forced 0 that cycle; burst accepted on a later cycle with the new H.
REQ-016 Burst accepted at edge t with BurstLen=N>0: OutputCLK=1, RiseStrobe=1, Busy=1 from cycle t+1; state HIGH.
REQ-017 HIGH and LOW SHALL each last exactly H cycles; output period 2H cycles; FallStrobe in first LOW cycle.
REQ-018 Remaining count SHALL decrement at end of each LOW phase; nonzero -> HIGH with RiseStrobe; zero -> IDLE with Done=1, Busy=0, OutputCLK=0.
REQ-019 BurstLen=0 accepted: no OutputCLK pulse; Done=1 in cycle t+1, Busy stays 0.
REQ-020 Total burst time SHALL be 2·H·N cycles from first high cycle to Done cycle (exclusive).
REQ-021 Maximum values (H=2^BITS_NUMBER-1, N=2^CNT_BITS-1) SHALL run without counter wrap.

Reset
REQ-022 Rst low SHALL immediately force: state IDLE, OutputCLK=0, strobes=0, Busy=0, Done=0, DivReady=BurstReady=0, H=INIT_DIVIDER, remaining count 0.
REQ-023 Reset mid-burst SHALL abort without Done; first cycle after release DivReady=BurstReady=1.

Configuration
REQ-024 With SCLK_FREE_RUN_EN defined: add input FreeRun; FreeRun=1 in IDLE starts continuous toggling with H (Busy=1, Ready=0); after FreeRun falls, stop at the end of the current LOW phase, no Done pulse.
REQ-025 Without SCLK_FREE_RUN_EN: no FreeRun port; burst mode only.

Structure
REQ-026 Package sclk_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-027 Sub-module sclk_phase_counter SHALL implement the loadable half-period down-counter with terminal-count flag.

Verification
REQ-028 Reset released, BurstValid with N=3 (H=125) -> 3 periods of 250 cycles, Done after 750 cycles, RiseStrobe×3, FallStrobe×3.
REQ-029 DivValue=5 then BurstLen=4 -> OutputCLK high 5 / low 5, Done 40 cycles after first high cycle.
REQ-030 DivValid+BurstValid same cycle (DivValue=2) -> BurstReady=0 that cycle; burst then runs with H=2.
REQ-031 DivValue=0, BurstLen=1 -> H=1, OutputCLK high 1 cycle, low 1 cycle, Done; BurstLen=0 -> Done next cycle, no pulse.
REQ-032 Rst low during second HIGH phase of N=5 burst -> OutputCLK=0 at once, no Done, H=INIT_DIVIDER afterwards.
REQ-033 SCLK_FREE_RUN_EN, H=3, FreeRun high 20 cycles -> continuous 6-cycle clock, stop after completing LOW, Busy falls, no Done.
